// File: rtl/sim_console.sv
// sim_console: memory-mapped simulation console (stdout FIFO, halt, cycle/instr counters)
// Latency: register reads one cycle (o_dout registered); a stdout byte is visible on o_tx_valid one cycle after its write
// Backpressure: o_stall while a RUN-state stdout write targets a full FIFO; bytes leave on o_tx_valid & i_tx_ready
//
// Ports:
//   i_clk, i_rstb, i_clk_en        clock, async active-low reset, global clock enable
//   i_addr, i_wr, i_rd, i_din      CPU data bus request; o_dout registered read data, o_stall wait request
//   i_instr_valid                  one pulse per retired instruction
//   o_tx_data, o_tx_valid, i_tx_ready  console byte stream
//   o_halt                         high once the system has halted and the console has drained
//
// Address map (A = all ones in AW bits): A HALT (wr), A-1 STDOUT (wr), A-2 STATUS (rd),
// A-3 CYCLES (rd), A-4 INSTRS (rd). Legal parameters: DW >= 16, CW <= DW, DEPTH a power of 2 >= 2
// and <= 255 so the level fits the 8-bit STATUS field.

// Generic synchronous FIFO; push/pop arrive already qualified with the clock enable.
// Latency: head entry visible the cycle after the push edge.
// Backpressure: pushes into a full FIFO and pops from an empty one are ignored.
module sim_console_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rstb,
  input  logic                       push,
  input  logic [W-1:0]               push_dat,
  input  logic                       pop,
  output logic [W-1:0]               head_dat,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // An empty FIFO presents zero so the byte output is clean out of reset.
  assign head_dat = empty ? '0 : mem[rd_ptr];

  // Storage needs no reset: nothing is visible until level says so.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers are exactly PW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

module sim_console #(
  parameter int AW    = 24,
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int CW    = 32
) (
  input  logic          i_clk,
  input  logic          i_rstb,
  input  logic          i_clk_en,
  input  logic [AW-1:0] i_addr,
  input  logic          i_wr,
  input  logic          i_rd,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_dout,
  output logic          o_stall,
  input  logic          i_instr_valid,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_valid,
  input  logic          i_tx_ready,
  output logic          o_halt
);
  localparam int LW = $clog2(DEPTH) + 1;

  localparam logic [AW-1:0] ADDR_HALT   = '1;
  localparam logic [AW-1:0] ADDR_STDOUT = ADDR_HALT - AW'(1);
  localparam logic [AW-1:0] ADDR_STATUS = ADDR_HALT - AW'(2);
  localparam logic [AW-1:0] ADDR_CYCLES = ADDR_HALT - AW'(3);
  localparam logic [AW-1:0] ADDR_INSTRS = ADDR_HALT - AW'(4);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cyc_cnt;
  logic [CW-1:0] instr_cnt;

  logic          sel_halt;
  logic          sel_stdout;
  logic          in_run;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic [7:0]    fifo_head;
  logic [DW-1:0] rd_mux;
  logic          unused_din;

  assign sel_halt   = (i_addr == ADDR_HALT);
  assign sel_stdout = (i_addr == ADDR_STDOUT);
  assign in_run     = (state == ST_RUN);

  // Only the low byte of a stdout write is a character.
  assign unused_din = ^i_din[DW-1:8];

  // Stall is purely a function of the present level, so a pop in the same
  // cycle does not release it; the write lands on the following edge.
  // Once halting has begun, stdout writes are dropped rather than stalled.
  assign o_stall   = i_wr && sel_stdout && fifo_full && in_run;
  assign fifo_push = i_clk_en && i_wr && sel_stdout && in_run && !fifo_full;
  assign fifo_pop  = i_clk_en && o_tx_valid && i_tx_ready;

  assign o_tx_valid = !fifo_empty;
  assign o_tx_data  = fifo_head;

  sim_console_fifo #(
    .W     (8),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .clk      (i_clk),
    .rstb     (i_rstb),
    .push     (fifo_push),
    .push_dat (i_din[7:0]),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .level    (fifo_level),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Read data source; undecoded and write-only addresses read as zero.
  always_comb begin
    rd_mux = '0;
    if (i_addr == ADDR_STATUS) begin
      rd_mux[15:8] = 8'(fifo_level);
      rd_mux[2]    = o_halt;
      rd_mux[1]    = fifo_full;
      rd_mux[0]    = fifo_empty;
    end else if (i_addr == ADDR_CYCLES) begin
      rd_mux = DW'(cyc_cnt);
    end else if (i_addr == ADDR_INSTRS) begin
      rd_mux = DW'(instr_cnt);
    end
  end

  // Control FSM, counters and registered read data. Counters wrap naturally
  // at 2^CW. The DRAIN->HALTED edge still counts as a DRAIN cycle.
  always_ff @(posedge i_clk or negedge i_rstb) begin
    if (!i_rstb) begin
      state     <= ST_RUN;
      o_halt    <= 1'b0;
      o_dout    <= '0;
      cyc_cnt   <= '0;
      instr_cnt <= '0;
    end else if (i_clk_en) begin
      if (i_rd) o_dout <= rd_mux;
      case (state)
        ST_RUN: begin
          cyc_cnt <= cyc_cnt + CW'(1);
          if (i_instr_valid) instr_cnt <= instr_cnt + CW'(1);
          if (i_wr && sel_halt) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          cyc_cnt <= cyc_cnt + CW'(1);
          // Level is the registered value, so a HALT written with an empty
          // FIFO spends exactly one cycle here before halting.
          if (fifo_empty) begin
            state  <= ST_HALTED;
            o_halt <= 1'b1;
          end
        end
        ST_HALTED: begin
          state <= ST_HALTED;
        end
        default: begin
          state  <= ST_RUN;
          o_halt <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/sim_console.md
SIM_CONSOLE -- requirements
Module: sim_console

Interface
REQ-001 Parameter AW, default 24, bus address width.
REQ-002 Parameter DW, default 32, bus data width; SHALL be >= 16.
REQ-003 Parameter DEPTH, default 16, TX FIFO entries; power of 2, >= 2.
REQ-004 Parameter CW, default 32, cycle/instruction counter width; SHALL be <= DW.
REQ-005 One clock; reset is asynchronous and active-low: i_clk input 1, rising-edge clock.
REQ-006 i_rstb input 1, asynchronous active-low reset.
REQ-007 i_clk_en input 1, global clock enable.
REQ-008 i_addr input AW, CPU data address.
REQ-009 i_wr input 1, write strobe.
REQ-010 i_rd input 1, read strobe.
REQ-011 i_din input DW, write data.
REQ-012 o_dout output DW, registered read data.
REQ-013 o_stall output 1, bus wait request.
REQ-014 i_instr_valid input 1, one pulse per retired instruction.
REQ-015 o_tx_data output 8, console byte.
REQ-016 o_tx_valid output 1, console byte available.
REQ-017 i_tx_ready input 1, sink accepts byte.
REQ-018 o_halt output 1, system halted.

Function
REQ-019 The block SHALL decode these addresses, with A = all-ones in AW bits: A = HALT (write), A-1 = STDOUT (write), A-2 = STATUS (read), A-3 = CYCLES (read), A-4 = INSTRS (read); all other addresses SHALL be ignored.
REQ-020 State updates SHALL occur only on rising i_clk edges with i_clk_en=1; with i_clk_en=0, all state SHALL hold.
REQ-021 A STDOUT write with the FIFO not full SHALL push i_din[7:0]; the upper bits SHALL be ignored.
REQ-022 o_stall SHALL be combinational: 1 if and only if i_wr=1, the address is STDOUT, and the FIFO is full.
  - A stalled write SHALL NOT push.
  - A same-cycle pop SHALL NOT clear the stall.
REQ-023 o_tx_valid SHALL be 1 if and only if the FIFO is non-empty; o_tx_data SHALL be the head entry.
  - A pop SHALL occur when o_tx_valid and i_tx_ready are both 1.
REQ-024 A simultaneous push and pop on a non-empty FIFO SHALL leave the level unchanged; read/write pointers SHALL wrap modulo DEPTH.
REQ-025 On a read, o_dout SHALL update on the edge where i_rd=1, giving one-cycle latency; o_dout SHALL hold otherwise.
  - Reads of undecoded addresses SHALL return 0.
REQ-026 STATUS SHALL read as follows: [15:8] = FIFO level (0..DEPTH), [2] = halted, [1] = FIFO full, [0] = FIFO empty; all other bits SHALL read 0.
REQ-027 CYCLES and INSTRS SHALL return the counter value zero-extended to DW.
REQ-028 The state machine SHALL have three states.
  - RUN: a HALT write (any data) SHALL move to DRAIN.
  - DRAIN: when the FIFO is empty, SHALL move to HALTED.
  - HALTED: terminal until reset.
REQ-029 o_halt SHALL be 1 only in HALTED.
REQ-030 In DRAIN and HALTED, STDOUT writes SHALL be dropped and SHALL NOT stall.
  - FIFO pops SHALL continue.
  - Reads SHALL still function.
REQ-031 A HALT write in the same cycle as an empty FIFO SHALL enter DRAIN; the transition to HALTED SHALL occur on the next enabled edge.
REQ-032 The cycle counter SHALL increment on every enabled edge in RUN and DRAIN, freeze in HALTED, and wrap from 2^CW-1 to 0.
REQ-033 The instruction counter SHALL increment on enabled edges with i_instr_valid=1 in RUN only, and wrap from 2^CW-1 to 0.
REQ-034 Simultaneous i_wr and i_rd SHALL both be honoured.

Reset
REQ-035 On i_rstb=0, the block SHALL asynchronously reset to: state RUN, FIFO empty, pointers 0, counters 0, o_dout=0, o_halt=0, o_tx_valid=0, o_tx_data=0.
REQ-036 Reset asserted mid-DRAIN or mid-transfer SHALL discard all FIFO contents; no partial state SHALL survive.
REQ-037 Reset deassertion SHALL take effect at the first rising edge after i_rstb rises.

Verification
REQ-038 Console order: i_tx_ready=1, write 0x48 then 0x69 to 0xFFFFFE -> o_tx_data 0x48 then 0x69, each valid one cycle after its write.
REQ-039 Full FIFO: i_tx_ready=0, 17 STDOUT writes -> o_stall=1 on the 17th write; STATUS reads 0x00001002; raising i_tx_ready -> the 17th write completes after one pop.
REQ-040 Drain halt: 3 bytes queued, i_tx_ready=0, write to 0xFFFFFF -> o_halt=0 while bytes remain; enable ready -> o_halt=1 exactly one cycle after the last pop; the cycle counter freezes.
REQ-041 Counters: 100 enabled cycles with 40 i_instr_valid pulses, read INSTRS -> 40; CYCLES -> 100 plus the read offset; i_clk_en=0 for 10 cycles -> no change.
REQ-042 Wrap: CW=4, 17 enabled cycles -> CYCLES reads 1.
REQ-043 Reset mid-DRAIN: pulse i_rstb low -> o_tx_valid=0, o_halt=0, and STATUS reads 0x00000001.
